// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch stage and its neighbours.
// NOP_OPCODE / NOP_WORD are also used by the decoder to recognise bubbles.
package instruction_fetch_unit_pkg;

  localparam logic [5:0]  NOP_OPCODE      = 6'b111111;
  localparam logic [31:0] NOP_WORD        = {26'd0, NOP_OPCODE};
  localparam int          PC_STEP_DEFAULT = 4;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory read bus between the fetch unit (master) and the
// instruction memory (slave).
//
// Handshake: the master raises Mem_Req with Mem_Addr and holds both stable
// until a cycle in which Mem_Ready=1; that cycle completes the transfer and
// Mem_Rdata is valid in it. Mem_Ready while Mem_Req=0 carries no meaning and
// is ignored by the master.
//
// Signals:
//   Mem_Req   master->slave  read request
//   Mem_Addr  master->slave  byte address of the word
//   Mem_Ready slave->master  completes the handshake
//   Mem_Rdata slave->master  32-bit instruction word
interface instruction_fetch_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  Mem_Req;
  logic [ADDR_WIDTH-1:0] Mem_Addr;
  logic                  Mem_Ready;
  logic [31:0]           Mem_Rdata;

  modport master (
    output Mem_Req,
    output Mem_Addr,
    input  Mem_Ready,
    input  Mem_Rdata
  );

  modport slave (
    input  Mem_Req,
    input  Mem_Addr,
    output Mem_Ready,
    output Mem_Rdata
  );
endinterface

// File: rtl/instruction_fetch_unit_fetch_skid_buffer.sv
// One-entry skid register holding a fetched word and its PC while the
// decoder is stalled.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   load, clear        capture data/addr, or drop the held entry
//   data, addr         word and PC to capture
//   held_word, held_pc held entry
//   full               an entry is held
module fetch_skid_buffer
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  clear,
  input  logic [31:0]           data,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [31:0]           held_word,
  output logic [ADDR_WIDTH-1:0] held_pc,
  output logic                  full
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held_word <= NOP_WORD;
      held_pc   <= '0;
      full      <= 1'b0;
    end else if (load) begin
      held_word <= data;
      held_pc   <= addr;
      full      <= 1'b1;
    end else if (clear) begin
      held_word <= NOP_WORD;
      full      <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory through the mem bus and
// presents one word per cycle to the decoder. A one-entry skid absorbs a word
// that returns while the decoder is stalled; branches redirect the PC, and a
// branch arriving mid-handshake is remembered (squash) until the outstanding
// read completes, whose data is then thrown away.
// Ports:
//   Clock, Reset_N      clock, synchronous active-low reset
//   Stall               decoder cannot take a new word
//   Branch_Taken/Target one-cycle redirect; target bits [1:0] ignored
//   mem                 instruction memory bus (master side)
//   Instruction         word to decoder, NOP_WORD when not valid
//   Instruction_Valid   Instruction is a real fetched word
//   PC_Out              address of the word on Instruction
//   Fetch_Busy          memory read outstanding
//   Fetch_State         current FSM state (debug)
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    PC_STEP    = PC_STEP_DEFAULT
) (
  input  logic                      Clock,
  input  logic                      Reset_N,
  input  logic                      Stall,
  input  logic                      Branch_Taken,
  input  logic [ADDR_WIDTH-1:0]     Branch_Target,
  instruction_fetch_unit_if.master  mem,
  output logic [31:0]               Instruction,
  output logic                      Instruction_Valid,
  output logic [ADDR_WIDTH-1:0]     PC_Out,
  output logic                      Fetch_Busy,
  output fetch_state_t              Fetch_State
);

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  fetch_state_t          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  squash;
  logic [ADDR_WIDTH-1:0] squash_target;
  logic [ADDR_WIDTH-1:0] target;

  logic                  skid_load;
  logic                  skid_clear;
  logic [31:0]           skid_word;
  logic [ADDR_WIDTH-1:0] skid_pc;
  logic                  skid_full;

  assign target = Branch_Target & ALIGN_MASK;

  // Request is a pure decode of the registered state, so Mem_Addr (= pc)
  // cannot move until the state machine sees Mem_Ready.
  assign mem.Mem_Req  = (state == S_FETCH);
  assign mem.Mem_Addr = pc;
  assign Fetch_Busy   = (state == S_FETCH);
  assign Fetch_State  = state;

  always_comb begin
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (state == S_FETCH && mem.Mem_Ready && !Branch_Taken && !squash && Stall)
      skid_load = 1'b1;
    if (state == S_HOLD && (Branch_Taken || !Stall))
      skid_clear = 1'b1;
  end

  fetch_skid_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_skid (
    .clk       (Clock),
    .rst_n     (Reset_N),
    .load      (skid_load),
    .clear     (skid_clear),
    .data      (mem.Mem_Rdata),
    .addr      (pc),
    .held_word (skid_word),
    .held_pc   (skid_pc),
    .full      (skid_full)
  );

  always_ff @(posedge Clock) begin
    if (!Reset_N) begin
      state             <= S_RESET;
      pc                <= RESET_PC;
      squash            <= 1'b0;
      squash_target     <= RESET_PC;
      Instruction       <= NOP_WORD;
      Instruction_Valid <= 1'b0;
      PC_Out            <= RESET_PC;
    end else begin
      case (state)
        S_RESET: state <= S_FETCH;

        S_FETCH: begin
          if (Branch_Taken) begin
            Instruction       <= NOP_WORD;
            Instruction_Valid <= 1'b0;
            if (mem.Mem_Ready) begin
              pc     <= target;
              squash <= 1'b0;
            end else begin
              // Address must stay put until the read completes.
              squash        <= 1'b1;
              squash_target <= target;
            end
          end else if (mem.Mem_Ready) begin
            if (squash) begin
              // Stale data from before the redirect.
              squash <= 1'b0;
              pc     <= squash_target;
              if (!Stall) begin
                Instruction       <= NOP_WORD;
                Instruction_Valid <= 1'b0;
              end
            end else if (Stall) begin
              state <= S_HOLD;
            end else begin
              Instruction       <= mem.Mem_Rdata;
              Instruction_Valid <= 1'b1;
              PC_Out            <= pc;
              pc                <= pc + STEP;
            end
          end else if (!Stall) begin
            // Decoder consumed the previous word and nothing new arrived.
            Instruction       <= NOP_WORD;
            Instruction_Valid <= 1'b0;
          end
        end

        S_HOLD: begin
          if (Branch_Taken) begin
            pc                <= target;
            Instruction       <= NOP_WORD;
            Instruction_Valid <= 1'b0;
            state             <= S_FETCH;
          end else if (!Stall) begin
            if (skid_full) begin
              Instruction       <= skid_word;
              PC_Out            <= skid_pc;
              Instruction_Valid <= 1'b1;
              pc                <= pc + STEP;
            end else begin
              Instruction       <= NOP_WORD;
              Instruction_Valid <= 1'b0;
            end
            state <= S_FETCH;
          end
        end

        default: state <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam int AW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          stall;
  logic          br;
  logic [31:0]   tgt;
  logic [31:0]   instr;
  logic          ivalid;
  logic [31:0]   pc_out;
  logic          busy;
  fetch_state_t  fstate;

  instruction_fetch_unit_if #(.ADDR_WIDTH(AW)) bus ();

  instruction_fetch_unit #(
    .ADDR_WIDTH (AW),
    .RESET_PC   (32'h0000_0000),
    .PC_STEP    (4)
  ) dut (
    .Clock             (clk),
    .Reset_N           (rst_n),
    .Stall             (stall),
    .Branch_Taken      (br),
    .Branch_Target     (tgt),
    .mem               (bus),
    .Instruction       (instr),
    .Instruction_Valid (ivalid),
    .PC_Out            (pc_out),
    .Fetch_Busy        (busy),
    .Fetch_State       (fstate)
  );

  // ---------------- scoreboard state ----------------
  int           total = 0;
  int           bad   = 0;
  logic [31:0]  exp_q[$];
  logic [31:0]  exp_pc;

  // memory model configuration
  int           wait_cfg  = 0;
  int           wait_left = 0;
  bit           wait_rand = 1'b0;
  bit           stray_en  = 1'b0;
  logic [31:0]  key       = 32'h0;

  // values seen just before the last edge
  logic         p_req, p_ready, p_valid;
  logic [31:0]  p_addr, p_instr, p_pcout;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ key;
  endfunction

  function automatic int next_wait();
    if (wait_rand) return int'($urandom_range(0, 2));
    return wait_cfg;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  // Memory answers after wait_left idle cycles, word = addr ^ key.
  task automatic cycle(input logic s, input logic b, input logic [31:0] t, input logic r);
    rst_n = r;
    stall = s;
    br    = b;
    tgt   = t;
    if (bus.Mem_Req !== 1'b1) begin
      wait_left     = next_wait();
      bus.Mem_Ready = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.Mem_Rdata = $urandom;
    end else if (wait_left == 0) begin
      bus.Mem_Ready = 1'b1;
      bus.Mem_Rdata = mem_word(bus.Mem_Addr);
    end else begin
      wait_left     = wait_left - 1;
      bus.Mem_Ready = 1'b0;
      bus.Mem_Rdata = $urandom;
    end
    p_req   = bus.Mem_Req;
    p_addr  = bus.Mem_Addr;
    p_ready = bus.Mem_Ready;
    p_valid = ivalid;
    p_instr = instr;
    p_pcout = pc_out;
    @(posedge clk);
    #1;
    if (!r) wait_left = next_wait();
    else if (p_req && p_ready) wait_left = next_wait();
  endtask

  task automatic run_to(input logic [31:0] a);
    int n = 0;
    while (bus.Mem_Addr !== a && n < 64) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end
    total++;
    if (bus.Mem_Addr !== a) begin
      bad++;
      $display("FAIL run_to: Mem_Addr=%h want %h", bus.Mem_Addr, a);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] e;
    wait_rand = 1'b0; wait_cfg = 0; stray_en = 1'b0; key = 32'h0;
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    total++; if (bus.Mem_Req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", bus.Mem_Req); end
    total++; if (bus.Mem_Addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus.Mem_Addr); end
    total++; if (instr !== NOP_WORD) begin bad++; $display("FAIL reset_instr: got %h want %h", instr, NOP_WORD); end
    total++; if (ivalid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", ivalid); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pcout: got %h want 0", pc_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (fstate !== S_RESET) begin bad++; $display("FAIL reset_state: got %0d want %0d", fstate, S_RESET); end
    // first cycle after release: request out, nothing valid yet
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    total++; if (ivalid !== 1'b0 || bus.Mem_Req !== 1'b1) begin
      bad++; $display("FAIL release_first: valid=%b req=%b want 0/1", ivalid, bus.Mem_Req);
    end
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      e = exp_q.pop_front();
      total++; if (ivalid !== 1'b1 || instr !== e || pc_out !== e) begin
        bad++; $display("FAIL seq_word%0d: valid=%b instr=%h pc=%h want %h", i, ivalid, instr, pc_out, e);
      end
    end
  endtask

  task automatic test_wait_states();
    wait_cfg = 3;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);   // 0xC completes, 0x10 gets 3 waits
    wait_cfg = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      total++; if (bus.Mem_Addr !== 32'h10 || busy !== 1'b1 || ivalid !== 1'b0) begin
        bad++; $display("FAIL wait_hold%0d: addr=%h busy=%b valid=%b want 10/1/0", i, bus.Mem_Addr, busy, ivalid);
      end
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    total++; if (ivalid !== 1'b1 || instr !== 32'h10 || pc_out !== 32'h10) begin
      bad++; $display("FAIL wait_data: valid=%b instr=%h pc=%h want 1/10/10", ivalid, instr, pc_out);
    end
  endtask

  task automatic test_stall();
    logic [31:0] h_instr, h_pc;
    stray_en = 1'b1;
    run_to(32'h20);
    h_instr = instr;
    h_pc    = pc_out;
    total++; if (h_instr !== 32'h1C) begin bad++; $display("FAIL stall_pre: instr=%h want 1c", h_instr); end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      total++; if (instr !== h_instr || pc_out !== h_pc || ivalid !== 1'b1 || bus.Mem_Req !== 1'b0) begin
        bad++; $display("FAIL stall_freeze%0d: instr=%h pc=%h valid=%b req=%b", i, instr, pc_out, ivalid, bus.Mem_Req);
      end
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    total++; if (instr !== 32'h20 || pc_out !== 32'h20 || ivalid !== 1'b1) begin
      bad++; $display("FAIL stall_release: instr=%h pc=%h valid=%b want 20/20/1", instr, pc_out, ivalid);
    end
    total++; if (bus.Mem_Req !== 1'b1 || bus.Mem_Addr !== 32'h24) begin
      bad++; $display("FAIL stall_next_req: req=%b addr=%h want 1/24", bus.Mem_Req, bus.Mem_Addr);
    end
    stray_en = 1'b0;
  endtask

  task automatic test_branch_wait();
    run_to(32'h3C);
    wait_cfg = 2;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);   // 0x3C completes, 0x40 gets 2 waits
    wait_cfg = 0;
    cycle(1'b0, 1'b1, 32'h100, 1'b1);
    total++; if (bus.Mem_Addr !== 32'h40 || ivalid !== 1'b0 || instr !== NOP_WORD) begin
      bad++; $display("FAIL br_wait_a: addr=%h valid=%b instr=%h want 40/0/NOP", bus.Mem_Addr, ivalid, instr);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    total++; if (bus.Mem_Addr !== 32'h40) begin bad++; $display("FAIL br_wait_b: addr=%h want 40", bus.Mem_Addr); end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);   // 0x40 returns and is dropped
    total++; if (ivalid !== 1'b0 || instr !== NOP_WORD || bus.Mem_Addr !== 32'h100) begin
      bad++; $display("FAIL br_discard: valid=%b instr=%h addr=%h want 0/NOP/100", ivalid, instr, bus.Mem_Addr);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    total++; if (ivalid !== 1'b1 || pc_out !== 32'h100 || instr !== 32'h100) begin
      bad++; $display("FAIL br_first: valid=%b pc=%h instr=%h want 1/100/100", ivalid, pc_out, instr);
    end
  endtask

  task automatic test_branch_hold();
    cycle(1'b1, 1'b0, 32'h0, 1'b1);
    total++; if (fstate !== S_HOLD || bus.Mem_Req !== 1'b0) begin
      bad++; $display("FAIL hold_enter: state=%0d req=%b want %0d/0", fstate, bus.Mem_Req, S_HOLD);
    end
    cycle(1'b1, 1'b1, 32'h203, 1'b1);
    total++; if (fstate !== S_FETCH || bus.Mem_Addr !== 32'h200 || ivalid !== 1'b0) begin
      bad++; $display("FAIL hold_branch: state=%0d addr=%h valid=%b want %0d/200/0", fstate, bus.Mem_Addr, ivalid, S_FETCH);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    total++; if (ivalid !== 1'b1 || instr !== 32'h200 || pc_out !== 32'h200) begin
      bad++; $display("FAIL hold_target_word: valid=%b instr=%h pc=%h want 1/200/200", ivalid, instr, pc_out);
    end
  endtask

  task automatic test_wrap_and_reset();
    cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    total++; if (bus.Mem_Addr !== 32'hFFFF_FFFC || ivalid !== 1'b0) begin
      bad++; $display("FAIL wrap_redirect: addr=%h valid=%b want fffffffc/0", bus.Mem_Addr, ivalid);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    total++; if (instr !== 32'hFFFF_FFFC || pc_out !== 32'hFFFF_FFFC || bus.Mem_Addr !== 32'h0) begin
      bad++; $display("FAIL wrap: instr=%h pc=%h addr=%h want fffffffc/fffffffc/0", instr, pc_out, bus.Mem_Addr);
    end
    wait_cfg = 3;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);   // 0x0 completes, 0x4 waits
    wait_cfg = 0;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    total++; if (busy !== 1'b1 || bus.Mem_Addr !== 32'h4) begin
      bad++; $display("FAIL mid_wait: busy=%b addr=%h want 1/4", busy, bus.Mem_Addr);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    total++; if (bus.Mem_Req !== 1'b0 || bus.Mem_Addr !== 32'h0 || busy !== 1'b0 || fstate !== S_RESET) begin
      bad++; $display("FAIL midreset_bus: req=%b addr=%h busy=%b state=%0d want 0/0/0/0", bus.Mem_Req, bus.Mem_Addr, busy, fstate);
    end
    total++; if (instr !== NOP_WORD || ivalid !== 1'b0 || pc_out !== 32'h0) begin
      bad++; $display("FAIL midreset_out: instr=%h valid=%b pc=%h want NOP/0/0", instr, ivalid, pc_out);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    total++; if (ivalid !== 1'b1 || instr !== 32'h0 || pc_out !== 32'h0) begin
      bad++; $display("FAIL restart: valid=%b instr=%h pc=%h want 1/0/0", ivalid, instr, pc_out);
    end
  endtask

  // Reference model: words reach the decoder in program order, one new word
  // per non-stalled valid cycle; a redirect restarts the order at the aligned
  // target; stalls freeze the decoder-facing outputs; NOP whenever invalid.
  task automatic test_random();
    logic        s, b;
    logic [31:0] t;
    int          presented = 0;
    key       = $urandom;
    wait_rand = 1'b1;
    stray_en  = 1'b1;
    exp_pc    = 32'h4;   // word 0x0 was just presented by the previous test
    for (int i = 0; i < 800; i++) begin
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 8);
      t = $urandom;
      cycle(s, b, t, 1'b1);
      if (!ivalid) begin
        total++; if (instr !== NOP_WORD) begin bad++; $display("FAIL rnd_nop @%0d: instr=%h", i, instr); end
      end
      if (p_req && !p_ready) begin
        total++; if (bus.Mem_Req !== 1'b1 || bus.Mem_Addr !== p_addr) begin
          bad++; $display("FAIL rnd_addr_hold @%0d: req=%b addr=%h want 1/%h", i, bus.Mem_Req, bus.Mem_Addr, p_addr);
        end
      end
      if (b) begin
        total++; if (ivalid !== 1'b0) begin bad++; $display("FAIL rnd_branch_bubble @%0d: valid=%b", i, ivalid); end
        exp_pc = {t[31:2], 2'b00};
      end else if (s) begin
        total++; if (instr !== p_instr || ivalid !== p_valid || pc_out !== p_pcout) begin
          bad++; $display("FAIL rnd_stall_freeze @%0d: instr=%h/%h valid=%b/%b pc=%h/%h", i, instr, p_instr, ivalid, p_valid, pc_out, p_pcout);
        end
      end else if (ivalid) begin
        total++; if (pc_out !== exp_pc || instr !== mem_word(exp_pc)) begin
          bad++; $display("FAIL rnd_word @%0d: pc=%h instr=%h want %h/%h", i, pc_out, instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'h4;
        presented++;
      end
    end
    total++; if (presented < 100) begin bad++; $display("FAIL rnd_progress: presented=%0d want >=100", presented); end
    wait_rand = 1'b0;
    stray_en  = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0; stall = 1'b0; br = 1'b0; tgt = 32'h0;
    bus.Mem_Ready = 1'b0; bus.Mem_Rdata = 32'h0;
    test_reset();
    test_wait_states();
    test_stall();
    test_branch_wait();
    test_branch_hold();
    test_wrap_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Holds the program counter and runs a request/ready handshake with instruction memory.
- Presents one 32-bit word per cycle on Instruction, with a valid flag, to the decoder.
- Absorbs downstream stalls with a one-entry skid buffer, handles branch redirects (including while a memory access is outstanding), and drives the NOP encoding (opcode 6'b111111) whenever no valid instruction is available.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- Clock  in  1  single clock; all state updates on rising edge.
- Reset_N  in  1  synchronous, active-low reset.
- Stall  in  1  decoder cannot accept a new instruction this cycle.
- Branch_Taken  in  1  one-cycle redirect request.
- Branch_Target  in  ADDR_WIDTH  redirect address; bits [1:0] are forced to 0.
- Mem_Req  out  1  instruction memory read request.
- Mem_Addr  out  ADDR_WIDTH  read address; held stable while Mem_Req=1 and Mem_Ready=0.
- Mem_Ready  in  1  read data valid on Mem_Rdata this cycle; completes the handshake.
- Mem_Rdata  in  32  instruction word.
- Instruction  out  32  word to the decoder; NOP word 32'h0000_003F when invalid.
- Instruction_Valid  out  1  Instruction holds a real fetched word.
- PC_Out  out  ADDR_WIDTH  address of the word on Instruction.
- Fetch_Busy  out  1  a memory transaction is outstanding.

Behaviour:
- Reset (Reset_N=0 at an edge) forces: state S_RESET; Mem_Req=0; Mem_Addr=RESET_PC; PC=RESET_PC; Instruction=32'h0000_003F; Instruction_Valid=0; PC_Out=RESET_PC; Fetch_Busy=0; skid empty; squash=0.
- Reset mid-transaction abandons the outstanding access. Instruction memory shares the same reset.
- States:
  - S_RESET: exits to S_FETCH on the first cycle Reset_N=1.
  - S_FETCH: Mem_Req=1, Mem_Addr=PC, Fetch_Busy=1.
  - S_HOLD: Mem_Req=0; the skid buffer holds a word.
- S_FETCH, Mem_Ready=1, squash=0, Branch_Taken=0, Stall=0: Instruction<=Mem_Rdata, Valid<=1, PC_Out<=PC, PC<=PC+PC_STEP. Stay in S_FETCH with a new request next cycle. Throughput is 1 word/cycle with zero-wait memory.
- S_FETCH, Mem_Ready=1, Stall=1 (no branch, no squash): Mem_Rdata goes to the skid buffer with its PC. Go to S_HOLD. Instruction and Valid are unchanged.
- S_HOLD, Stall=0: Instruction<=skid word, PC_Out<=skid PC, Valid<=1, PC<=PC+PC_STEP, skid cleared, go to S_FETCH.
- Latency: Mem_Ready in cycle M means Instruction is valid from cycle M+1.
- Stall=1 freezes Instruction, Instruction_Valid and PC_Out.
- Branch_Taken has priority over Stall and over any returning data:
  - S_FETCH with Mem_Ready=1 same cycle: returned word is discarded; PC<=target; next cycle requests target.
  - S_FETCH with Mem_Ready=0: Mem_Addr cannot change mid-handshake. Set squash=1 and latch the target. On the later Mem_Ready, discard the data, clear squash, PC<=latched target, request target next cycle.
  - A second branch while squash=1 overwrites the latched target.
  - S_HOLD: skid is discarded; PC<=target; go to S_FETCH.
  - Every branch drives Instruction=NOP and Valid=0 from the next edge until the first post-branch word is captured.
- PC arithmetic is modulo 2^ADDR_WIDTH: 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- Mem_Rdata is sampled only when Mem_Ready=1 and Mem_Req=1. Mem_Ready with Mem_Req=0 is ignored.

Decomposition:
- Shared package holds:
  - NOP_OPCODE = 6'b111111 and NOP_WORD = 32'h0000_003F, also used by the decoder.
  - The fetch-state enum {S_RESET, S_FETCH, S_HOLD}.
  - PC_STEP default.
- One natural sub-module, fetch_skid_buffer: a one-entry word+PC register with load, clear and a full flag.

Test Plan:
- Reset_N low for 2 cycles, then high, with zero-wait memory returning word=addr: Instruction follows 0x0,0x4,0x8 on consecutive cycles; first Valid appears 2 cycles after reset release.
- Mem_Ready delayed 3 cycles on address 0x10: Mem_Addr holds 0x10 and Fetch_Busy=1 throughout; Instruction is valid with the 0x10 word one cycle after Ready.
- Stall=1 for 4 cycles while word 0x20 returns: Instruction and PC_Out frozen; Mem_Req=0 in S_HOLD; after Stall drops, 0x20 is presented, then 0x24 is requested.
- Branch_Taken to 0x100 during a 2-cycle wait on 0x40: 0x40 data is discarded, Valid=0 with NOP, next Mem_Addr=0x100, and PC_Out=0x100 when the first valid word appears.
- Branch_Taken and Stall asserted together in S_HOLD: skid is discarded and Branch_Target=0x203 results in Mem_Addr=0x200.
- PC=0xFFFF_FFFC fetched: next Mem_Addr=0x0000_0000; Reset_N low mid-wait drives all outputs to reset values at the next edge.
